// File: rtl/game_seq_pkg.sv
// game_seq_pkg: shared definitions for the rhythm-game run controller.
//   seq_state_e   - FSM state encodings (also driven out on the state port)
//   COUNTDOWN_MAX - largest countdown that fits the 4-bit display digit
//   LOAD_CNT_W    - width of the saturating pattern-download cycle counter
//   sat_inc       - saturating increment for the download counter
package game_seq_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_LOAD      = 3'd1,
    ST_COUNTDOWN = 3'd2,
    ST_PLAY      = 3'd3,
    ST_PAUSE     = 3'd4,
    ST_RESULT    = 3'd5
  } seq_state_e;

  localparam int COUNTDOWN_MAX = 15;
  localparam int LOAD_CNT_W    = 16;

  function automatic logic [LOAD_CNT_W-1:0] sat_inc(input logic [LOAD_CNT_W-1:0] v);
    return (&v) ? v : v + LOAD_CNT_W'(1);
  endfunction

endpackage

// File: rtl/game_sequencer_sec_tick.sv
// sec_tick_divider: free-running seconds prescaler.
//   CLOCK50M - system clock
//   reset    - synchronous active-high reset
//   clr      - synchronous restart of the count (used on every FSM state entry)
//   tick     - high for the last cycle of each TICKS_PER_SEC-cycle period
module sec_tick_divider #(
  parameter int TICKS_PER_SEC = 50000000
) (
  input  logic CLOCK50M,
  input  logic reset,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICKS_PER_SEC - 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge CLOCK50M) begin
    if (reset || clr) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign tick = (cnt == LAST);

endmodule

// File: rtl/game_sequencer.sv
// game_sequencer: run controller for the rhythm-game datapath.
// Phases: IDLE -> LOAD (pattern download) -> IDLE -> COUNTDOWN -> PLAY <-> PAUSE
// -> RESULT. All outputs are registered and change on the edge that samples
// the causing input.
//   CLOCK50M, reset            - clock, synchronous active-high reset
//   host_write                 - raw host download strobe (gated into load_en)
//   start_req/pause_req/abort_req - one-cycle key pulses
//   game_timer, song_length    - song position / end from game_clock
//   load_en                    - gated write enable, only in LOAD
//   timer_run/timer_clear      - game_clock advance / one-cycle clear
//   score_clear                - one-cycle clear to score_calculator
//   countdown_digit            - seconds remaining in COUNTDOWN, else 0
//   loaded                     - a non-empty pattern set is held
//   game_over                  - high in RESULT
//   write_rejected             - host_write rose during COUNTDOWN/PLAY/PAUSE
//   state                      - current state encoding
// Build option: define AUTO_REPLAY_EN to restart the countdown automatically
// after RESULT_HOLD_SEC seconds in RESULT without host activity.
module game_sequencer
  import game_seq_pkg::*;
#(
  parameter int TIMER_W         = 10,
  parameter int COUNTDOWN_SEC   = 3,
  parameter int TICKS_PER_SEC   = 50000000,
  parameter int RESULT_HOLD_SEC = 5
) (
  input  logic               CLOCK50M,
  input  logic               reset,
  input  logic               host_write,
  input  logic               start_req,
  input  logic               pause_req,
  input  logic               abort_req,
  input  logic [TIMER_W-1:0] game_timer,
  input  logic [TIMER_W-1:0] song_length,
  output logic               load_en,
  output logic               timer_run,
  output logic               timer_clear,
  output logic               score_clear,
  output logic [3:0]         countdown_digit,
  output logic               loaded,
  output logic               game_over,
  output logic               write_rejected,
  output logic [2:0]         state
);

  // Out-of-range countdown lengths are clamped to what the digit can show.
  localparam logic [3:0] CD_INIT =
    4'((COUNTDOWN_SEC > COUNTDOWN_MAX) ? COUNTDOWN_MAX : COUNTDOWN_SEC);

  seq_state_e            state_q, state_next;
  logic [LOAD_CNT_W-1:0] load_cnt, nxt_load_cnt;
  logic                  host_write_d;
  logic                  sec_tick, entering, abort_clr;
  logic                  nxt_load_en, nxt_timer_run, nxt_timer_clear, nxt_score_clear;
  logic                  nxt_loaded, nxt_game_over, nxt_write_rej;
  logic [3:0]            nxt_digit;

`ifdef AUTO_REPLAY_EN
  localparam logic [7:0] HOLD_LAST = 8'((RESULT_HOLD_SEC > 0) ? RESULT_HOLD_SEC - 1 : 0);
  logic [7:0] hold_cnt, hold_nxt;
`else
  // RESULT is held until a key or host write; the hold time has no effect.
  logic unused_hold_sec;
  assign unused_hold_sec = (RESULT_HOLD_SEC != 0);
`endif

  // The seconds counter restarts on every state entry so each phase counts
  // whole seconds from its own first cycle.
  sec_tick_divider #(
    .TICKS_PER_SEC(TICKS_PER_SEC)
  ) u_sec_tick (
    .CLOCK50M(CLOCK50M),
    .reset   (reset),
    .clr     (entering),
    .tick    (sec_tick)
  );

  always_comb begin
    state_next   = state_q;
    nxt_load_cnt = load_cnt;
    nxt_loaded   = loaded;
    abort_clr    = 1'b0;
`ifdef AUTO_REPLAY_EN
    hold_nxt     = hold_cnt;
`endif

    case (state_q)
      ST_IDLE: begin
        if (host_write) begin
          state_next = ST_LOAD;
          nxt_loaded = 1'b0;
        end else if (start_req && loaded) begin
          state_next = ST_COUNTDOWN;
        end
      end
      ST_LOAD: begin
        // The entry cycle only detects the strobe; cycles spent in LOAD with
        // the strobe high are what count as downloaded data.
        if (host_write) begin
          nxt_load_cnt = sat_inc(load_cnt);
        end else begin
          state_next = ST_IDLE;
          nxt_loaded = (load_cnt != '0);
        end
      end
      ST_COUNTDOWN: begin
        if (abort_req) begin
          state_next = ST_IDLE;
        end else if (sec_tick && countdown_digit <= 4'd1) begin
          state_next = ST_PLAY;
        end
      end
      ST_PLAY: begin
        if (abort_req) begin
          state_next = ST_IDLE;
          abort_clr  = 1'b1;
        end else if (game_timer >= song_length) begin
          state_next = ST_RESULT;
        end else if (pause_req) begin
          state_next = ST_PAUSE;
        end
      end
      ST_PAUSE: begin
        if (abort_req) begin
          state_next = ST_IDLE;
          abort_clr  = 1'b1;
        end else if (pause_req) begin
          state_next = ST_PLAY;
        end
      end
      ST_RESULT: begin
        if (host_write) begin
          state_next = ST_LOAD;
          nxt_loaded = 1'b0;
        end else if (start_req) begin
          state_next = ST_COUNTDOWN;
        end
`ifdef AUTO_REPLAY_EN
        else if (sec_tick) begin
          if (hold_cnt == HOLD_LAST) begin
            state_next = ST_COUNTDOWN;
          end else begin
            hold_nxt = hold_cnt + 8'd1;
          end
        end
`endif
      end
      default: state_next = ST_IDLE;
    endcase

    entering = (state_next != state_q);
    if (entering) begin
      nxt_load_cnt = '0;
`ifdef AUTO_REPLAY_EN
      hold_nxt     = '0;
`endif
    end

    nxt_digit = 4'd0;
    if (state_next == ST_COUNTDOWN) begin
      if (entering) begin
        nxt_digit = CD_INIT;
      end else if (sec_tick) begin
        nxt_digit = countdown_digit - 4'd1;
      end else begin
        nxt_digit = countdown_digit;
      end
    end

    nxt_load_en     = (state_next == ST_LOAD) && host_write;
    nxt_timer_run   = (state_next == ST_PLAY);
    nxt_game_over   = (state_next == ST_RESULT);
    nxt_score_clear = entering && (state_next == ST_COUNTDOWN);
    nxt_timer_clear = nxt_score_clear || abort_clr;
    nxt_write_rej   = host_write && !host_write_d &&
                      (state_q == ST_COUNTDOWN || state_q == ST_PLAY || state_q == ST_PAUSE);
  end

  always_ff @(posedge CLOCK50M) begin
    if (reset) begin
      state_q         <= ST_IDLE;
      load_cnt        <= '0;
      host_write_d    <= 1'b0;
      load_en         <= 1'b0;
      timer_run       <= 1'b0;
      timer_clear     <= 1'b0;
      score_clear     <= 1'b0;
      countdown_digit <= 4'd0;
      loaded          <= 1'b0;
      game_over       <= 1'b0;
      write_rejected  <= 1'b0;
    end else begin
      state_q         <= state_next;
      load_cnt        <= nxt_load_cnt;
      host_write_d    <= host_write;
      load_en         <= nxt_load_en;
      timer_run       <= nxt_timer_run;
      timer_clear     <= nxt_timer_clear;
      score_clear     <= nxt_score_clear;
      countdown_digit <= nxt_digit;
      loaded          <= nxt_loaded;
      game_over       <= nxt_game_over;
      write_rejected  <= nxt_write_rej;
    end
  end

`ifdef AUTO_REPLAY_EN
  always_ff @(posedge CLOCK50M) begin
    if (reset) begin
      hold_cnt <= '0;
    end else begin
      hold_cnt <= hold_nxt;
    end
  end
`endif

  assign state = state_q;

endmodule

// File: tb/tb_game_sequencer.sv
// Testbench for game_sequencer: directed scenario tasks plus a randomized run
// checked against a cycle-count based reference model.
module tb_game_sequencer;

  localparam int TW   = 10;
  localparam int CS   = 3;
  localparam int TPS  = 4;
  localparam int HOLD = 2;

  logic          CLOCK50M = 1'b0;
  logic          reset = 1'b1;
  logic          host_write = 1'b0, start_req = 1'b0, pause_req = 1'b0, abort_req = 1'b0;
  logic [TW-1:0] game_timer = '0, song_length = 10'd1000;
  logic          load_en, timer_run, timer_clear, score_clear;
  logic [3:0]    countdown_digit;
  logic          loaded, game_over, write_rejected;
  logic [2:0]    state;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 CLOCK50M = ~CLOCK50M;

  game_sequencer #(
    .TIMER_W(TW), .COUNTDOWN_SEC(CS), .TICKS_PER_SEC(TPS), .RESULT_HOLD_SEC(HOLD)
  ) dut (
    .CLOCK50M(CLOCK50M), .reset(reset), .host_write(host_write),
    .start_req(start_req), .pause_req(pause_req), .abort_req(abort_req),
    .game_timer(game_timer), .song_length(song_length),
    .load_en(load_en), .timer_run(timer_run), .timer_clear(timer_clear),
    .score_clear(score_clear), .countdown_digit(countdown_digit), .loaded(loaded),
    .game_over(game_over), .write_rejected(write_rejected), .state(state)
  );

  task automatic cyc();
    @(posedge CLOCK50M);
    #1;
  endtask

  task automatic wait_state(input logic [2:0] s, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (state == s) begin
        ok = 1'b1;
        break;
      end
      cyc();
    end
  endtask

  // Reset, then download a short pattern so the block sits in IDLE with loaded=1.
  task automatic prep_loaded();
    host_write = 0; start_req = 0; pause_req = 0; abort_req = 0;
    game_timer = '0; song_length = 10'd1000;
    reset = 1; cyc(); reset = 0;
    host_write = 1; repeat (3) cyc();
    host_write = 0; cyc();
  endtask

  task automatic test_reset();
    reset = 1; cyc(); cyc();
    n_checks++; if (state !== 3'd0) begin n_fails++; $display("FAIL reset_state: got %0d expected 0", state); end
    n_checks++; if ({load_en, timer_run, timer_clear, score_clear, loaded, game_over, write_rejected} !== 7'b0) begin
      n_fails++; $display("FAIL reset_outputs: got %b expected 0000000",
        {load_en, timer_run, timer_clear, score_clear, loaded, game_over, write_rejected}); end
    n_checks++; if (countdown_digit !== 4'd0) begin n_fails++; $display("FAIL reset_digit: got %0d expected 0", countdown_digit); end
    reset = 0; start_req = 1; cyc(); start_req = 0;
    n_checks++; if (state !== 3'd0) begin n_fails++; $display("FAIL reset_start_unloaded: got %0d expected 0", state); end
  endtask

  task automatic test_load_start();
    int n_en;
    bit ok;
    n_en = 0;
    for (int i = 0; i < 10; i++) begin
      host_write = (i < 8);
      cyc();
      if (load_en) n_en++;
    end
    n_checks++; if (n_en != 8) begin n_fails++; $display("FAIL load_en_cycles: got %0d expected 8", n_en); end
    n_checks++; if (state !== 3'd0 || loaded !== 1'b1) begin n_fails++;
      $display("FAIL load_done: got state=%0d loaded=%b expected state=0 loaded=1", state, loaded); end
    start_req = 1; cyc(); start_req = 0;
    n_checks++; if ({state, timer_clear, score_clear, countdown_digit} !== {3'd2, 1'b1, 1'b1, 4'd3}) begin n_fails++;
      $display("FAIL cd_entry: got state=%0d tclr=%b sclr=%b digit=%0d expected 2 1 1 3",
               state, timer_clear, score_clear, countdown_digit); end
    for (int e = 1; e < CS * TPS; e++) begin
      cyc();
      n_checks++; if (state !== 3'd2 || countdown_digit !== 4'(CS - e / TPS)) begin n_fails++;
        $display("FAIL cd_digit[%0d]: got state=%0d digit=%0d expected state=2 digit=%0d",
                 e, state, countdown_digit, CS - e / TPS); end
      if (e == 1) begin
        n_checks++; if (timer_clear !== 1'b0 || score_clear !== 1'b0) begin n_fails++;
          $display("FAIL cd_clear_width: got tclr=%b sclr=%b expected 0 0", timer_clear, score_clear); end
      end
    end
    cyc();
    n_checks++; if ({state, timer_run, countdown_digit} !== {3'd3, 1'b1, 4'd0}) begin n_fails++;
      $display("FAIL play_entry: got state=%0d run=%b digit=%0d expected 3 1 0", state, timer_run, countdown_digit); end
    abort_req = 1; cyc(); abort_req = 0;
    n_checks++; if ({state, timer_clear, timer_run, loaded} !== {3'd0, 1'b1, 1'b0, 1'b1}) begin n_fails++;
      $display("FAIL play_abort: got state=%0d tclr=%b run=%b loaded=%b expected 0 1 0 1",
               state, timer_clear, timer_run, loaded); end
    ok = 1'b1;
  endtask

  task automatic test_empty_load_priority();
    prep_loaded();
    host_write = 1; cyc(); host_write = 0; cyc();
    n_checks++; if (state !== 3'd0 || loaded !== 1'b0) begin n_fails++;
      $display("FAIL empty_load: got state=%0d loaded=%b expected 0 0", state, loaded); end
    start_req = 1; cyc(); start_req = 0; cyc();
    n_checks++; if (state !== 3'd0) begin n_fails++; $display("FAIL empty_start_ignored: got %0d expected 0", state); end
    host_write = 1; start_req = 1; cyc(); start_req = 0;
    n_checks++; if (state !== 3'd1 || load_en !== 1'b1) begin n_fails++;
      $display("FAIL write_beats_start: got state=%0d load_en=%b expected 1 1", state, load_en); end
    cyc(); cyc(); host_write = 0; cyc();
    n_checks++; if (state !== 3'd0 || loaded !== 1'b1 || load_en !== 1'b0) begin n_fails++;
      $display("FAIL reload: got state=%0d loaded=%b load_en=%b expected 0 1 0", state, loaded, load_en); end
  endtask

  task automatic test_song_end();
    bit ok;
    prep_loaded();
    song_length = 10'd20; game_timer = 10'd0;
    start_req = 1; cyc(); start_req = 0;
    wait_state(3'd3, 40, ok);
    n_checks++; if (!ok) begin n_fails++; $display("FAIL song_reach_play: got state=%0d expected 3", state); end
    game_timer = 10'd19; cyc();
    n_checks++; if (state !== 3'd3) begin n_fails++; $display("FAIL song_before_end: got %0d expected 3", state); end
    game_timer = 10'd20; cyc();
    n_checks++; if ({state, game_over, timer_run} !== {3'd5, 1'b1, 1'b0}) begin n_fails++;
      $display("FAIL song_end: got state=%0d over=%b run=%b expected 5 1 0", state, game_over, timer_run); end
    song_length = 10'd0;
    start_req = 1; cyc(); start_req = 0;
    n_checks++; if (state !== 3'd2 || loaded !== 1'b1) begin n_fails++;
      $display("FAIL replay: got state=%0d loaded=%b expected 2 1", state, loaded); end
    wait_state(3'd3, 40, ok);
    n_checks++; if (!ok || timer_run !== 1'b1) begin n_fails++;
      $display("FAIL zero_len_play: got state=%0d run=%b expected 3 1", state, timer_run); end
    cyc();
    n_checks++; if (state !== 3'd5) begin n_fails++; $display("FAIL zero_len_result: got %0d expected 5", state); end
  endtask

  task automatic test_result_hold();
    bit ok;
    int n;
    prep_loaded();
    song_length = 10'd0;
    start_req = 1; cyc(); start_req = 0;
    wait_state(3'd5, 40, ok);
    n_checks++; if (!ok) begin n_fails++; $display("FAIL hold_reach_result: got state=%0d expected 5", state); end
    n = 0;
`ifdef AUTO_REPLAY_EN
    while (state == 3'd5 && n < 50) begin cyc(); n++; end
    n_checks++; if (n != HOLD * TPS || state !== 3'd2) begin n_fails++;
      $display("FAIL auto_replay: got %0d cycles state=%0d expected %0d cycles state=2", n, state, HOLD * TPS); end
    n_checks++; if (countdown_digit !== 4'(CS) || timer_clear !== 1'b1) begin n_fails++;
      $display("FAIL auto_replay_entry: got digit=%0d tclr=%b expected %0d 1", countdown_digit, timer_clear, CS); end
`else
    for (int i = 0; i < 100; i++) begin cyc(); if (state != 3'd5) n++; end
    n_checks++; if (n != 0 || game_over !== 1'b1) begin n_fails++;
      $display("FAIL result_hold: got %0d cycles outside RESULT over=%b expected 0 1", n, game_over); end
`endif
  endtask

  task automatic test_pause_abort();
    bit ok;
    prep_loaded();
    start_req = 1; cyc(); start_req = 0;
    wait_state(3'd3, 40, ok);
    n_checks++; if (!ok) begin n_fails++; $display("FAIL pause_reach_play: got state=%0d expected 3", state); end
    pause_req = 1; cyc(); pause_req = 0;
    n_checks++; if (state !== 3'd4 || timer_run !== 1'b0) begin n_fails++;
      $display("FAIL pause: got state=%0d run=%b expected 4 0", state, timer_run); end
    repeat (6) cyc();
    n_checks++; if (state !== 3'd4) begin n_fails++; $display("FAIL pause_hold: got %0d expected 4", state); end
    pause_req = 1; cyc(); pause_req = 0;
    n_checks++; if (state !== 3'd3 || timer_run !== 1'b1) begin n_fails++;
      $display("FAIL resume: got state=%0d run=%b expected 3 1", state, timer_run); end
    abort_req = 1; pause_req = 1; cyc(); abort_req = 0; pause_req = 0;
    n_checks++; if (state !== 3'd0 || timer_clear !== 1'b1 || timer_run !== 1'b0) begin n_fails++;
      $display("FAIL abort_over_pause: got state=%0d tclr=%b run=%b expected 0 1 0", state, timer_clear, timer_run); end
    cyc();
    n_checks++; if (timer_clear !== 1'b0) begin n_fails++; $display("FAIL abort_clear_width: got %b expected 0", timer_clear); end
  endtask

  task automatic test_write_reject_reset();
    bit ok;
    prep_loaded();
    start_req = 1; cyc(); start_req = 0;
    wait_state(3'd3, 40, ok);
    host_write = 1; cyc();
    n_checks++; if ({write_rejected, load_en, state} !== {1'b1, 1'b0, 3'd3}) begin n_fails++;
      $display("FAIL reject_pulse: got rej=%b load_en=%b state=%0d expected 1 0 3", write_rejected, load_en, state); end
    cyc();
    n_checks++; if ({write_rejected, load_en, state} !== {1'b0, 1'b0, 3'd3}) begin n_fails++;
      $display("FAIL reject_width: got rej=%b load_en=%b state=%0d expected 0 0 3", write_rejected, load_en, state); end
    host_write = 0; abort_req = 1; cyc(); abort_req = 0;
    start_req = 1; cyc(); start_req = 0; cyc();
    n_checks++; if (state !== 3'd2) begin n_fails++; $display("FAIL reset_pre_cd: got %0d expected 2", state); end
    reset = 1; cyc(); reset = 0;
    n_checks++; if ({state, countdown_digit, load_en, timer_run, timer_clear, score_clear, loaded, game_over, write_rejected} !== 14'b0) begin
      n_fails++; $display("FAIL reset_mid_cd: got state=%0d digit=%0d flags=%b expected all 0", state, countdown_digit,
        {load_en, timer_run, timer_clear, score_clear, loaded, game_over, write_rejected}); end
    start_req = 1; cyc(); start_req = 0;
    n_checks++; if (state !== 3'd0) begin n_fails++; $display("FAIL reset_discards_load: got %0d expected 0", state); end
  endtask

  // Reference model: tracks the phase and how many cycles have elapsed in it.
  // Countdown and auto-replay are timed as fixed cycle budgets
  // (COUNTDOWN_SEC*TICKS_PER_SEC, RESULT_HOLD_SEC*TICKS_PER_SEC).
  task automatic test_random();
    int ms, ns, mel, mcnt, hw_left, shown;
    bit mloaded, nloaded, mhw_d, aclr, auto_en;
    logic [13:0] exp_v, got_v;
    logic [3:0] e_digit;
`ifdef AUTO_REPLAY_EN
    auto_en = 1'b1;
`else
    auto_en = 1'b0;
`endif
    host_write = 0; start_req = 0; pause_req = 0; abort_req = 0;
    reset = 1; cyc(); reset = 0;
    ms = 0; mel = 0; mcnt = 0; mloaded = 0; mhw_d = 0; hw_left = 0; shown = 0;
    for (int c = 0; c < 3000; c++) begin
      if (hw_left == 0 && $urandom_range(0, 39) == 0) hw_left = $urandom_range(1, 6);
      host_write  = (hw_left > 0);
      if (hw_left > 0) hw_left--;
      start_req   = ($urandom_range(0, 5) == 0);
      pause_req   = ($urandom_range(0, 9) == 0);
      abort_req   = ($urandom_range(0, 29) == 0);
      song_length = ($urandom_range(0, 15) == 0) ? 10'd0 : 10'd200;
      game_timer  = 10'($urandom_range(0, 255));

      ns = ms; nloaded = mloaded; aclr = 0;
      case (ms)
        0: if (host_write) begin ns = 1; nloaded = 0; end else if (start_req && mloaded) ns = 2;
        1: if (!host_write) begin ns = 0; nloaded = (mcnt > 0); end
        2: if (abort_req) ns = 0; else if (mel == CS * TPS - 1) ns = 3;
        3: if (abort_req) begin ns = 0; aclr = 1; end
           else if (game_timer >= song_length) ns = 5; else if (pause_req) ns = 4;
        4: if (abort_req) begin ns = 0; aclr = 1; end else if (pause_req) ns = 3;
        default: if (host_write) begin ns = 1; nloaded = 0; end else if (start_req) ns = 2;
                 else if (auto_en && mel == HOLD * TPS - 1) ns = 2;
      endcase
      e_digit = 4'd0;
      if (ns == 2) e_digit = 4'(CS - ((ns != ms) ? 0 : (mel + 1)) / TPS);
      exp_v = {3'(ns), e_digit, (ns == 1) && host_write, ns == 3, ((ns == 2) && (ms != 2)) || aclr,
               (ns == 2) && (ms != 2), nloaded, ns == 5,
               host_write && !mhw_d && (ms == 2 || ms == 3 || ms == 4)};
      if (ns == 1 && ms == 1 && host_write) mcnt++;
      else if (ns != ms) mcnt = 0;
      mel = (ns != ms) ? 0 : mel + 1;
      ms = ns; mloaded = nloaded; mhw_d = host_write;

      cyc();
      got_v = {state, countdown_digit, load_en, timer_run, timer_clear, score_clear, loaded, game_over, write_rejected};
      n_checks++;
      if (got_v !== exp_v) begin
        n_fails++;
        if (shown < 20) begin
          shown++;
          $display("FAIL random[%0d]: got %b expected %b (state,digit,load_en,run,tclr,sclr,loaded,over,rej)",
                   c, got_v, exp_v);
        end
      end
    end
    start_req = 0; pause_req = 0; abort_req = 0; host_write = 0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_load_start();
    test_empty_load_priority();
    test_song_end();
    test_result_hold();
    test_pause_abort();
    test_write_reject_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
